// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues one command at a time to a registered-output 16-bit ALU and returns one response per command
// CLK/RST          clock, asynchronous active-low reset
// CMD_*            command handshake (VALID/READY) carrying A, B, FUN
// ALU_A/B/FUN      registered drive to the ALU; ALU_OUT/ALU_CARRY/class flags come back
// RSP_*            response handshake (VALID/READY) carrying DATA, CARRY, ERR[0]=div-by-zero, ERR[1]=class mismatch
// OP_COUNT         completed responses; ERR_COUNT responses with nonzero ERR (both wrap)
module alu_cmd_sequencer #(
  parameter int         WIDTH    = 16,
  parameter logic [3:0] IDLE_FUN = 4'b1111,
  parameter int         CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [WIDTH-1:0] CMD_A,
  input  logic [WIDTH-1:0] CMD_B,
  input  logic [3:0]       CMD_FUN,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [3:0]       ALU_FUN,
  input  logic [WIDTH-1:0] ALU_OUT,
  input  logic             ALU_CARRY,
  input  logic             ALU_ARITH,
  input  logic             ALU_LOGIC,
  input  logic             ALU_CMP,
  input  logic             ALU_SHIFT,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic             RSP_CARRY,
  output logic [1:0]       RSP_ERR,
  output logic [CNT_W-1:0] OP_COUNT,
  output logic [CNT_W-1:0] ERR_COUNT
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [3:0] op_fun;
  logic [3:0] cls_exp;
  logic       div0;
  // expected {arith, logic, cmp, shift} for the op in flight
  always_comb
    cls_exp = op_fun <= 4'd3  ? 4'b1000 :
              op_fun <= 4'd9  ? 4'b0100 :
              op_fun <= 4'd12 ? 4'b0010 :
              op_fun <= 4'd14 ? 4'b0001 : 4'b0000;
  assign div0      = CMD_FUN == 4'b0011 && CMD_B == '0;
  // gated by RST so the combinational ready is low while reset is held
  assign CMD_READY = RST && state == IDLE;
  assign RSP_VALID = state == DONE;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state     <= IDLE;
      op_fun    <= IDLE_FUN;
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_FUN   <= IDLE_FUN;
      RSP_DATA  <= '0;
      RSP_CARRY <= 1'b0;
      RSP_ERR   <= 2'b00;
      OP_COUNT  <= '0;
      ERR_COUNT <= '0;
    end else
      case (state)
        IDLE:
          if (CMD_VALID && CMD_READY) begin
            op_fun  <= CMD_FUN;
            RSP_ERR <= div0 ? 2'b01 : 2'b00;
            if (div0) begin
              // refused without touching the ALU
              RSP_DATA  <= '1;
              RSP_CARRY <= 1'b0;
              state     <= DONE;
            end else begin
              ALU_A   <= CMD_A;
              ALU_B   <= CMD_B;
              ALU_FUN <= CMD_FUN;
              state   <= ISSUE;
            end
          end
        ISSUE: begin
          // ALU samples its inputs on this edge; flags still reflect op_fun
          ALU_FUN    <= IDLE_FUN;
          RSP_ERR[1] <= op_fun != 4'b1111 && {ALU_ARITH, ALU_LOGIC, ALU_CMP, ALU_SHIFT} != cls_exp;
          state      <= CAPTURE;
        end
        CAPTURE: begin
          RSP_DATA  <= ALU_OUT;
          RSP_CARRY <= op_fun <= 4'd1 ? ALU_CARRY : 1'b0;
          state     <= DONE;
        end
        DONE:
          if (RSP_READY) begin
            OP_COUNT <= OP_COUNT + CNT_W'(1);
            if (|RSP_ERR) ERR_COUNT <= ERR_COUNT + CNT_W'(1);
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed tests of alu_cmd_sequencer against a registered-output ALU model
module tb_alu_cmd_sequencer;
  logic        CLK, RST, CMD_VALID, CMD_READY, RSP_VALID, RSP_READY, RSP_CARRY;
  logic [15:0] CMD_A, CMD_B, ALU_A, ALU_B, RSP_DATA;
  logic [3:0]  CMD_FUN, ALU_FUN;
  logic [15:0] alu_out;
  logic        alu_carry, alu_arith, alu_logic, alu_cmp, alu_shift, force_cmp_zero;
  logic [1:0]  RSP_ERR;
  logic [2:0]  OP_COUNT, ERR_COUNT;
  int total, bad, cyc, last_acc;
  alu_cmd_sequencer #(.WIDTH(16), .IDLE_FUN(4'b1111), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_FUN(CMD_FUN),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .ALU_OUT(alu_out), .ALU_CARRY(alu_carry),
    .ALU_ARITH(alu_arith), .ALU_LOGIC(alu_logic), .ALU_CMP(alu_cmp), .ALU_SHIFT(alu_shift),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_CARRY(RSP_CARRY),
    .RSP_ERR(RSP_ERR), .OP_COUNT(OP_COUNT), .ERR_COUNT(ERR_COUNT)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  // ALU model: class flags decode ALU_FUN combinationally, result/carry registered
  assign alu_arith = ALU_FUN <= 4'd3;
  assign alu_logic = ALU_FUN >= 4'd4 && ALU_FUN <= 4'd9;
  assign alu_cmp   = ALU_FUN >= 4'd10 && ALU_FUN <= 4'd12 && !force_cmp_zero;
  assign alu_shift = ALU_FUN == 4'd13 || ALU_FUN == 4'd14;
  initial begin alu_out = '0; alu_carry = 1'b0; end
  always @(posedge CLK) begin
    alu_carry <= 1'b0;
    case (ALU_FUN)
      4'b0000: {alu_carry, alu_out} <= {1'b0, ALU_A} + {1'b0, ALU_B};
      4'b0001: {alu_carry, alu_out} <= {1'b0, ALU_A} - {1'b0, ALU_B};
      4'b0010: alu_out <= ALU_A * ALU_B;
      4'b0011: alu_out <= ALU_B == '0 ? '0 : ALU_A / ALU_B;
      4'b0100: alu_out <= ALU_A & ALU_B;
      4'b0101: alu_out <= ALU_A | ALU_B;
      4'b0110: alu_out <= ~(ALU_A & ALU_B);
      4'b0111: alu_out <= ~(ALU_A | ALU_B);
      4'b1000: alu_out <= ALU_A ^ ALU_B;
      4'b1001: alu_out <= ~(ALU_A ^ ALU_B);
      4'b1010: alu_out <= ALU_A == ALU_B ? 16'd1 : 16'd0;
      4'b1011: alu_out <= ALU_A > ALU_B ? 16'd2 : 16'd0;
      4'b1100: alu_out <= ALU_A < ALU_B ? 16'd3 : 16'd0;
      4'b1101: alu_out <= ALU_A >> 1;
      4'b1110: alu_out <= ALU_A << 1;
      default: alu_out <= '0;
    endcase
  end
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    int n = 0;
    CMD_A = a; CMD_B = b; CMD_FUN = f; CMD_VALID = 1'b1;
    while (!CMD_READY && n < 20) begin @(negedge CLK); n++; end
    total++;
    if (CMD_READY !== 1'b1) begin bad++; $display("FAIL issue_ready got=%b want=1", CMD_READY); end
    last_acc = cyc;
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask
  task automatic wait_rsp;
    int n = 0;
    while (!RSP_VALID && n < 20) begin @(negedge CLK); n++; end
  endtask
  task automatic take;
    RSP_READY = 1'b1;
    @(negedge CLK);
    RSP_READY = 1'b0;
  endtask
  task automatic test_reset;
    RST = 1'b0; CMD_VALID = 1'b0; RSP_READY = 1'b0; force_cmp_zero = 1'b0;
    CMD_A = '0; CMD_B = '0; CMD_FUN = '0;
    repeat (3) @(negedge CLK);
    total++;
    if ({CMD_READY, RSP_VALID, ALU_A, ALU_B, ALU_FUN, RSP_DATA, RSP_CARRY, RSP_ERR, OP_COUNT, ERR_COUNT} !==
        {1'b0, 1'b0, 16'h0, 16'h0, 4'hF, 16'h0, 1'b0, 2'b00, 3'd0, 3'd0}) begin
      bad++;
      $display("FAIL reset_vals got rdy=%b vld=%b a=%h b=%h fun=%h d=%h c=%b e=%b op=%0d er=%0d want 0,0,0,0,f,0,0,0,0,0",
               CMD_READY, RSP_VALID, ALU_A, ALU_B, ALU_FUN, RSP_DATA, RSP_CARRY, RSP_ERR, OP_COUNT, ERR_COUNT);
    end
    RST = 1'b1;
    @(negedge CLK);
    total++;
    if (CMD_READY !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", CMD_READY); end
  endtask
  task automatic test_add_carry;
    issue(16'hFFFF, 16'h0001, 4'b0000);
    total++;
    if ({RSP_VALID, ALU_FUN, ALU_A, ALU_B} !== {1'b0, 4'b0000, 16'hFFFF, 16'h0001}) begin
      bad++; $display("FAIL add_issue got vld=%b fun=%b a=%h b=%h want 0 0000 ffff 0001", RSP_VALID, ALU_FUN, ALU_A, ALU_B);
    end
    @(negedge CLK);
    total++;
    if ({RSP_VALID, ALU_FUN, ALU_A} !== {1'b0, 4'b1111, 16'hFFFF}) begin
      bad++; $display("FAIL add_capture got vld=%b fun=%b a=%h want 0 1111 ffff", RSP_VALID, ALU_FUN, ALU_A);
    end
    @(negedge CLK);
    total++;
    if ({RSP_VALID, RSP_DATA, RSP_CARRY, RSP_ERR} !== {1'b1, 16'h0000, 1'b1, 2'b00}) begin
      bad++; $display("FAIL add_rsp got vld=%b d=%h c=%b e=%b want 1 0000 1 00", RSP_VALID, RSP_DATA, RSP_CARRY, RSP_ERR);
    end
    take();
    total++;
    if ({RSP_VALID, OP_COUNT, ERR_COUNT} !== {1'b0, 3'd1, 3'd0}) begin
      bad++; $display("FAIL add_count got vld=%b op=%0d er=%0d want 0 1 0", RSP_VALID, OP_COUNT, ERR_COUNT);
    end
  endtask
  task automatic test_div_zero;
    issue(16'h0010, 16'h0000, 4'b0011);
    total++;
    if ({RSP_VALID, ALU_FUN, RSP_DATA, RSP_ERR, RSP_CARRY} !== {1'b1, 4'b1111, 16'hFFFF, 2'b01, 1'b0}) begin
      bad++; $display("FAIL div0_rsp got vld=%b fun=%b d=%h e=%b c=%b want 1 1111 ffff 01 0",
                      RSP_VALID, ALU_FUN, RSP_DATA, RSP_ERR, RSP_CARRY);
    end
    take();
    total++;
    if ({OP_COUNT, ERR_COUNT, ALU_FUN} !== {3'd2, 3'd1, 4'b1111}) begin
      bad++; $display("FAIL div0_count got op=%0d er=%0d fun=%b want 2 1 1111", OP_COUNT, ERR_COUNT, ALU_FUN);
    end
  endtask
  task automatic test_cmp_flags;
    issue(16'd5, 16'd3, 4'b1011);
    wait_rsp();
    total++;
    if ({RSP_VALID, RSP_DATA, RSP_CARRY, RSP_ERR} !== {1'b1, 16'd2, 1'b0, 2'b00}) begin
      bad++; $display("FAIL cmp_rsp got vld=%b d=%h c=%b e=%b want 1 0002 0 00", RSP_VALID, RSP_DATA, RSP_CARRY, RSP_ERR);
    end
    take();
    force_cmp_zero = 1'b1;
    issue(16'd5, 16'd3, 4'b1011);
    wait_rsp();
    force_cmp_zero = 1'b0;
    total++;
    if ({RSP_VALID, RSP_DATA, RSP_ERR} !== {1'b1, 16'd2, 2'b10}) begin
      bad++; $display("FAIL cmp_flag_err got vld=%b d=%h e=%b want 1 0002 10", RSP_VALID, RSP_DATA, RSP_ERR);
    end
    take();
    total++;
    if ({OP_COUNT, ERR_COUNT} !== {3'd4, 3'd2}) begin
      bad++; $display("FAIL cmp_count got op=%0d er=%0d want 4 2", OP_COUNT, ERR_COUNT);
    end
  endtask
  task automatic test_stall;
    issue(16'h8001, 16'h0000, 4'b1110);
    wait_rsp();
    CMD_A = 16'h0001; CMD_B = 16'h0001; CMD_FUN = 4'b0000; CMD_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({RSP_VALID, RSP_DATA, CMD_READY, RSP_ERR} !== {1'b1, 16'h0002, 1'b0, 2'b00}) begin
        bad++; $display("FAIL stall_%0d got vld=%b d=%h rdy=%b e=%b want 1 0002 0 00", i, RSP_VALID, RSP_DATA, CMD_READY, RSP_ERR);
      end
      @(negedge CLK);
    end
    CMD_VALID = 1'b0;
    take();
    total++;
    if ({RSP_VALID, CMD_READY, OP_COUNT, ERR_COUNT} !== {1'b0, 1'b1, 3'd5, 3'd2}) begin
      bad++; $display("FAIL stall_done got vld=%b rdy=%b op=%0d er=%0d want 0 1 5 2", RSP_VALID, CMD_READY, OP_COUNT, ERR_COUNT);
    end
  endtask
  task automatic test_reset_mid;
    issue(16'h0001, 16'h0002, 4'b0000);
    @(negedge CLK);
    RSP_READY = 1'b1;
    RST = 1'b0;
    #1;
    total++;
    if ({CMD_READY, RSP_VALID, ALU_A, ALU_B, ALU_FUN, RSP_DATA, RSP_ERR, OP_COUNT} !==
        {1'b0, 1'b0, 16'h0, 16'h0, 4'hF, 16'h0, 2'b00, 3'd0}) begin
      bad++; $display("FAIL rst_mid got rdy=%b vld=%b a=%h b=%h fun=%h d=%h e=%b op=%0d want 0 0 0 0 f 0 00 0",
                      CMD_READY, RSP_VALID, ALU_A, ALU_B, ALU_FUN, RSP_DATA, RSP_ERR, OP_COUNT);
    end
    @(negedge CLK);
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    total++;
    if ({RSP_VALID, CMD_READY, OP_COUNT, ERR_COUNT} !== {1'b0, 1'b1, 3'd0, 3'd0}) begin
      bad++; $display("FAIL rst_mid_after got vld=%b rdy=%b op=%0d er=%0d want 0 1 0 0", RSP_VALID, CMD_READY, OP_COUNT, ERR_COUNT);
    end
    RSP_READY = 1'b0;
  endtask
  task automatic test_back_to_back;
    int acc[3];
    RSP_READY = 1'b1;
    issue(16'd10, 16'd3, 4'b0001); acc[0] = last_acc;
    issue(16'h00F0, 16'h0F0F, 4'b0100); acc[1] = last_acc;
    issue(16'd3, 16'd4, 4'b0000); acc[2] = last_acc;
    repeat (4) @(negedge CLK);
    total++;
    if (acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4) begin
      bad++; $display("FAIL b2b_spacing got %0d,%0d want 4,4", acc[1] - acc[0], acc[2] - acc[1]);
    end
    total++;
    if ({OP_COUNT, RSP_VALID, RSP_DATA, RSP_CARRY} !== {3'd3, 1'b0, 16'd7, 1'b0}) begin
      bad++; $display("FAIL b2b_count got op=%0d vld=%b d=%h c=%b want 3 0 0007 0", OP_COUNT, RSP_VALID, RSP_DATA, RSP_CARRY);
    end
  endtask
  task automatic test_wrap;
    for (int i = 0; i < 5; i++) issue(16'd300, 16'd300, 4'b0010);
    repeat (4) @(negedge CLK);
    total++;
    if ({OP_COUNT, ERR_COUNT, RSP_DATA} !== {3'd0, 3'd0, 16'h5F90}) begin
      bad++; $display("FAIL wrap got op=%0d er=%0d d=%h want 0 0 5f90", OP_COUNT, ERR_COUNT, RSP_DATA);
    end
    RSP_READY = 1'b0;
  endtask
  initial begin
    total = 0; bad = 0; last_acc = 0;
    test_reset();
    test_add_carry();
    test_div_zero();
    test_cmp_flags();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
